// File: rtl/axi_wbeat_gen.sv
// rtl/axi_wbeat_gen.sv - AXI W beat generator driven by snooped AW burst lengths
module axi_wbeat_gen #(
  parameter int AXI_DW     = 128,
  parameter int AXI_LW     = 8,
  parameter int AXI_WSTRBW = AXI_DW / 8,
  parameter int LQ_D       = 4,
  parameter int LQ_CW      = $clog2(LQ_D + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [AXI_LW-1:0]     axlen,
  input  logic                  axvalid,
  input  logic                  axready,
  output logic                  lq_full,
  output logic [LQ_CW-1:0]      lq_cnt,
  input  logic [AXI_DW-1:0]     src_data,
  input  logic                  src_valid,
  output logic                  src_ready,
  output logic [AXI_DW-1:0]     wdata,
  output logic [AXI_WSTRBW-1:0] wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic                  err_w1c,
  output logic                  err_ovf,
  output logic                  idle
);

  localparam int PW = (LQ_D > 1) ? $clog2(LQ_D) : 1;

  logic [AXI_LW-1:0] lq_mem [LQ_D];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [AXI_LW-1:0] beat_cnt;
  logic [AXI_LW-1:0] hd_len;
  logic              hd_ok;
  logic              push;
  logic              pop;
  logic              push_acc;
  logic              ovf;
  logic              w_fire;

  // The head burst is visible only once its length has been registered,
  // which gives the one-cycle push-to-wvalid latency.
  assign hd_ok     = (lq_cnt != '0);
  assign hd_len    = lq_mem[rd_ptr];

  assign wvalid    = src_valid & hd_ok;
  assign src_ready = wready & hd_ok;
  assign wdata     = src_data;
  assign wstrb     = '1;
  assign wlast     = hd_ok & (beat_cnt == hd_len);
  assign w_fire    = wvalid & wready;

  // A full queue can still take a push when the head retires in the same cycle.
  assign push      = axvalid & axready;
  assign pop       = w_fire & wlast;
  assign push_acc  = push & (~lq_full | pop);
  assign ovf       = push & lq_full & ~pop;

  assign lq_full   = (lq_cnt == LQ_CW'(LQ_D));
  assign idle      = (lq_cnt == '0) & (beat_cnt == '0);

  // Length storage; entries are only consumed when lq_cnt says they are valid.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      lq_mem[wr_ptr] <= axlen;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lq_cnt <= '0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push_acc && !pop) begin
        lq_cnt <= lq_cnt + LQ_CW'(1);
      end else if (pop && !push_acc) begin
        lq_cnt <= lq_cnt - LQ_CW'(1);
      end
    end
  end

  // Beat counter for the head burst; it restarts on the last beat so a
  // full-length burst reaches wlast before it could wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt <= '0;
    end else if (w_fire) begin
      if (wlast) begin
        beat_cnt <= '0;
      end else begin
        beat_cnt <= beat_cnt + AXI_LW'(1);
      end
    end
  end

  // Sticky overflow flag; a new overflow wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_ovf <= 1'b0;
    end else if (ovf) begin
      err_ovf <= 1'b1;
    end else if (err_w1c) begin
      err_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_wbeat_gen.sv
// tb/tb_axi_wbeat_gen.sv - directed vector bench for axi_wbeat_gen
module tb_axi_wbeat_gen;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   axlen;
  logic         axvalid;
  logic         axready;
  logic         lq_full;
  logic [2:0]   lq_cnt;
  logic [127:0] src_data;
  logic         src_valid;
  logic         src_ready;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic         err_w1c;
  logic         err_ovf;
  logic         idle;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_wbeat_gen dut (
    .clk(clk), .reset(reset), .axlen(axlen), .axvalid(axvalid), .axready(axready),
    .lq_full(lq_full), .lq_cnt(lq_cnt), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .err_w1c(err_w1c), .err_ovf(err_ovf), .idle(idle)
  );

  typedef struct {
    logic       rst;
    logic       axv;
    logic [7:0] len;
    logic       sv;
    logic       wr;
    logic       w1c;
    logic       e_wv;
    logic       e_sr;
    logic       e_wl;
    logic [2:0] e_cnt;
    logic       e_full;
    logic       e_err;
    logic       e_idle;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic row(input logic rst, input logic axv, input logic [7:0] len, input logic sv,
                     input logic wr, input logic w1c, input logic wv, input logic sr,
                     input logic wl, input logic [2:0] cnt, input logic full,
                     input logic err, input logic idl);
    vec_t v;
    v.rst = rst; v.axv = axv; v.len = len; v.sv = sv; v.wr = wr; v.w1c = w1c;
    v.e_wv = wv; v.e_sr = sr; v.e_wl = wl; v.e_cnt = cnt; v.e_full = full;
    v.e_err = err; v.e_idle = idl;
    tbl.push_back(v);
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; axvalid = 1'b0; src_valid = 1'b0; wready = 1'b0; err_w1c = 1'b0;
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats;
    int k;
    int nlast;
    int lastpos[$];
    logic fired;
    logic prev_stall;
    logic [127:0] prev_data;
    logic prev_last;
    logic [7:0] lens [4];

    reset = 1'b1; axvalid = 1'b0; axready = 1'b1; axlen = '0; src_valid = 1'b0;
    src_data = '0; wready = 1'b0; err_w1c = 1'b0;

    //   rst axv len sv wr w1c | wv sr wl cnt full err idle
    row(1, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 1);
    row(0, 1, 3, 1, 1, 0,   0, 0, 0, 0, 0, 0, 1);
    row(0, 0, 0, 1, 1, 0,   1, 1, 0, 1, 0, 0, 0);
    row(0, 0, 0, 1, 1, 0,   1, 1, 0, 1, 0, 0, 0);
    row(0, 0, 0, 1, 1, 0,   1, 1, 0, 1, 0, 0, 0);
    row(0, 0, 0, 1, 1, 0,   1, 1, 1, 1, 0, 0, 0);
    row(0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 1);
    row(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1);
    row(0, 1, 1, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0);
    row(0, 1, 2, 0, 0, 0,   0, 0, 1, 2, 0, 0, 0);
    row(0, 1, 3, 0, 0, 0,   0, 0, 1, 3, 0, 0, 0);
    row(0, 1, 9, 0, 0, 0,   0, 0, 1, 4, 1, 0, 0);
    row(0, 1, 9, 0, 0, 1,   0, 0, 1, 4, 1, 1, 0);
    row(0, 0, 0, 0, 1, 1,   0, 1, 1, 4, 1, 1, 0);
    row(0, 0, 0, 0, 0, 0,   0, 0, 1, 4, 1, 0, 0);
    row(0, 1, 5, 1, 1, 0,   1, 1, 1, 4, 1, 0, 0);
    row(0, 0, 0, 0, 0, 0,   0, 0, 0, 4, 1, 0, 0);
    row(1, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 1);
    row(0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 1);

    next_cycle();
    foreach (tbl[i]) begin
      reset = tbl[i].rst; axvalid = tbl[i].axv; axlen = tbl[i].len;
      src_valid = tbl[i].sv; wready = tbl[i].wr; err_w1c = tbl[i].w1c;
      src_data = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk($sformatf("v%0d wvalid", i), wvalid, tbl[i].e_wv);
      chk($sformatf("v%0d src_ready", i), src_ready, tbl[i].e_sr);
      chk($sformatf("v%0d wlast", i), wlast, tbl[i].e_wl);
      chk($sformatf("v%0d lq_cnt", i), lq_cnt, tbl[i].e_cnt);
      chk($sformatf("v%0d lq_full", i), lq_full, tbl[i].e_full);
      chk($sformatf("v%0d err_ovf", i), err_ovf, tbl[i].e_err);
      chk($sformatf("v%0d idle", i), idle, tbl[i].e_idle);
      chk($sformatf("v%0d wdata", i), wdata, src_data);
      chk($sformatf("v%0d wstrb", i), wstrb, 16'hffff);
      next_cycle();
    end
    err_w1c = 1'b0;

    // back-to-back lengths 0,1,15,0 then stream
    do_reset();
    lens[0] = 8'd0; lens[1] = 8'd1; lens[2] = 8'd15; lens[3] = 8'd0;
    wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      axvalid = 1'b1; axlen = lens[i];
      next_cycle();
    end
    axvalid = 1'b0;
    @(negedge clk);
    chk("seq42 peak lq_cnt", lq_cnt, 3'd4);
    chk("seq42 peak lq_full", lq_full, 1'b1);
    next_cycle();
    src_valid = 1'b1;
    beats = 0;
    for (int c = 0; c < 60 && beats < 20; c++) begin
      @(negedge clk);
      if (wvalid && wready) begin
        beats++;
        if (wlast) lastpos.push_back(beats);
      end
      next_cycle();
    end
    chk("seq42 beats", beats, 20);
    chk("seq42 wlast count", lastpos.size(), 4);
    if (lastpos.size() == 4) begin
      chk("seq42 wlast0", lastpos[0], 1);
      chk("seq42 wlast1", lastpos[1], 3);
      chk("seq42 wlast2", lastpos[2], 19);
      chk("seq42 wlast3", lastpos[3], 20);
    end
    @(negedge clk);
    chk("seq42 idle after", idle, 1'b1);
    chk("seq42 wvalid after", wvalid, 1'b0);
    next_cycle();

    // random stalls on an 8-beat burst
    do_reset();
    axvalid = 1'b1; axlen = 8'd7;
    next_cycle();
    axvalid = 1'b0;
    k = 0; fired = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    for (int c = 0; c < 300 && k < 8; c++) begin
      if (!(src_valid && !fired)) src_valid = 1'($urandom_range(0, 1));
      src_data = 128'hA000 + 128'(k);
      wready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (prev_stall) begin
        chk("seq45 held wvalid", wvalid, 1'b1);
        chk("seq45 held wdata", wdata, prev_data);
        chk("seq45 held wlast", wlast, prev_last);
      end
      fired = wvalid & wready;
      if (fired) begin
        chk($sformatf("seq45 beat%0d data", k), wdata, 128'hA000 + 128'(k));
        chk($sformatf("seq45 beat%0d wlast", k), wlast, 1'(k == 7));
        k++;
      end
      prev_stall = wvalid & ~wready;
      prev_data = wdata;
      prev_last = wlast;
      next_cycle();
    end
    chk("seq45 fire count", k, 8);
    src_valid = 1'b1; wready = 1'b1;
    beats = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (wvalid) beats++;
      next_cycle();
    end
    chk("seq45 extra beats", beats, 0);

    // full-length burst of 256 beats
    do_reset();
    axvalid = 1'b1; axlen = 8'hff;
    next_cycle();
    axvalid = 1'b0; src_valid = 1'b1; wready = 1'b1;
    beats = 0; nlast = 0;
    for (int c = 0; c < 400 && nlast == 0; c++) begin
      @(negedge clk);
      if (wvalid && wready) begin
        beats++;
        if (wlast) nlast = beats;
      end
      next_cycle();
    end
    chk("len255 wlast beat", nlast, 256);
    @(negedge clk);
    chk("len255 idle after", idle, 1'b1);
    next_cycle();

    // reset mid-burst
    do_reset();
    axvalid = 1'b1; axlen = 8'd7;
    next_cycle();
    axvalid = 1'b0; src_valid = 1'b1; wready = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("seq46 pre-reset wvalid", wvalid, 1'b1);
    next_cycle();
    reset = 1'b1;
    #1;
    chk("seq46 rst wvalid", wvalid, 1'b0);
    chk("seq46 rst idle", idle, 1'b1);
    chk("seq46 rst lq_cnt", lq_cnt, 3'd0);
    next_cycle();
    reset = 1'b0;
    beats = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (wvalid) beats++;
      next_cycle();
    end
    chk("seq46 beats after release", beats, 0);
    axvalid = 1'b1; axlen = 8'd0;
    @(negedge clk);
    chk("seq46 push cycle wvalid", wvalid, 1'b0);
    next_cycle();
    axvalid = 1'b0;
    @(negedge clk);
    chk("seq46 new burst wvalid", wvalid, 1'b1);
    chk("seq46 new burst wlast", wlast, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("seq46 final idle", idle, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_wbeat_gen.md
AXI_WBEAT_GEN -- requirements
Module: axi_wbeat_gen

Interface
REQ-001 SHALL have parameter AXI_DW, default 128, meaning W data bus width in bits.
REQ-002 SHALL have parameter AXI_LW, default 8, meaning AXLEN width.
REQ-003 SHALL have parameter AXI_WSTRBW, default AXI_DW/8, meaning WSTRB width.
REQ-004 SHALL have parameter LQ_D, default 4, meaning burst-length queue depth (power of two, >=2).
REQ-005 SHALL have parameter LQ_CW, default $clog2(LQ_D+1), meaning queue occupancy counter width.
REQ-006 clk  in  1  sole clock, all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 axlen  in  AXI_LW  burst length (beats-1) of the AW burst currently offered downstream.
REQ-009 axvalid  in  1  AW channel valid, snooped.
REQ-010 axready  in  1  AW channel ready, snooped.
REQ-011 lq_full  out  1  queue full; upstream address generator must hold axvalid low while set.
REQ-012 lq_cnt  out  LQ_CW  number of queued bursts not yet fully written.
REQ-013 src_data  in  AXI_DW  source data stream.
REQ-014 src_valid  in  1  source data valid.
REQ-015 src_ready  out  1  source data accepted.
REQ-016 wdata  out  AXI_DW  AXI W data.
REQ-017 wstrb  out  AXI_WSTRBW  AXI W strobe.
REQ-018 wlast  out  1  last beat of burst.
REQ-019 wvalid  out  1  AXI W valid.
REQ-020 wready  in  1  AXI W ready.
REQ-021 err_w1c  in  1  clears the sticky error flag.
REQ-022 err_ovf  out  1  sticky flag: push attempted while queue full.
REQ-023 idle  out  1  no queued bursts and no burst in progress.

Function
REQ-024 Push: axvalid&axready; axlen is written at the queue tail and the tail pointer advances, unless the queue is full and no pop occurs in the same cycle.
REQ-025 Push while full without a simultaneous pop SHALL be dropped, leave the queue unchanged, and set err_ovf on the next edge.
REQ-026 Push while full with a simultaneous pop SHALL be accepted; lq_cnt stays unchanged.
REQ-027 Push-to-visibility latency SHALL be 1 cycle: a burst pushed into an empty queue drives wvalid no earlier than the following cycle.
REQ-028 hd_ok = (lq_cnt != 0); wvalid = src_valid & hd_ok; src_ready = wready & hd_ok; wdata = src_data; wstrb = all ones (all combinational, no added latency).
REQ-029 W fire: wvalid&wready.
REQ-030 beat_cnt (AXI_LW bits) SHALL count accepted beats of the head burst; wlast = hd_ok & (beat_cnt == head axlen).
REQ-031 On W fire with wlast: pop the head, beat_cnt <= 0. On W fire without wlast: beat_cnt <= beat_cnt+1.
REQ-032 axlen=0 SHALL produce a single beat with wlast=1.
REQ-033 axlen=2^AXI_LW-1 SHALL produce 2^AXI_LW beats; beat_cnt SHALL NOT wrap before wlast.
REQ-034 lq_cnt_next = lq_cnt + push_accepted - pop; lq_full = (lq_cnt == LQ_D); pointers wrap modulo LQ_D.
REQ-035 idle = (lq_cnt==0) & (beat_cnt==0).
REQ-036 err_ovf SHALL stay set until err_w1c=1; if err_w1c and a new overflow occur in the same cycle, err_ovf remains 1.
REQ-037 Outputs SHALL be stable while wvalid=1 and wready=0, provided src_data and src_valid are held (source obeys the AXI-stream rule).

Reset
REQ-038 While reset=1: lq_cnt=0, pointers=0, beat_cnt=0, err_ovf=0.
REQ-039 Resulting outputs: wvalid=0, src_ready=0, wlast=0, lq_full=0, idle=1.
REQ-040 Reset asserted mid-burst SHALL discard all queued bursts and the partial beat count; after release, no W beat is issued until a new push.

Verification
REQ-041 Push axlen=3, src_valid=1, wready=1 constantly -> 4 beats on consecutive cycles starting the cycle after push, wlast only on beat 4, idle=1 after.
REQ-042 Push axlen=0,1,15,0 back-to-back, then stream -> beat groups 1,2,16,1 with wlast at beats 1,3,19,20; lq_cnt peaks at 4, lq_full=1 at that point.
REQ-043 Fill queue (4 pushes), then a 5th push with no pop -> err_ovf=1, lq_cnt stays 4; err_w1c pulse -> err_ovf=0.
REQ-044 Queue full, 5th push coincides with the wlast fire of the head -> push accepted, lq_cnt=4, err_ovf stays 0.
REQ-045 Randomly toggle wready and src_valid during axlen=7 -> exactly 8 fires, wdata/wlast held stable while stalled, beat order preserved.
REQ-046 Assert reset at beat 2 of an axlen=7 burst -> wvalid=0, idle=1, lq_cnt=0 immediately; no beats after release until a new push.
